// File: rtl/uart_leds7_pkg.sv
// Shared definitions for the UART-to-seven-segment receiver.
// Provides the receiver state enum, the bit-period helper and the
// active-low {g,f,e,d,c,b,a} segment lookup for hex digits 0..F.
package uart_leds7_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  // Rounded clock cycles per serial bit; clk_mhz in MHz, rate in bit/s.
  function automatic int unsigned clks_per_bit(input int unsigned clk_mhz,
                                               input int unsigned rate);
    return (clk_mhz * 1_000_000 + rate / 2) / rate;
  endfunction

  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/uart_leds7_rx_hex_to_7seg.sv
// Combinational hex digit to active-low seven-segment decoder.
// Ports: value - 4-bit nibble; seg_c - {g,f,e,d,c,b,a}, active-low.
module hex_to_7seg
  import uart_leds7_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg_c
);

  assign seg_c = SEG_LUT[value];

endmodule

// File: rtl/uart_leds7_rx.sv
// 8N1 UART receiver that shows the last good byte on two hex displays.
// Ports: clk, reset (sync, active-high), uart_rx (async serial, idles high),
//        data (last good byte), data_valid / frame_error (1-cycle pulses),
//        hex0 / hex1 (low / high nibble, active-low gfedcba).
module uart_leds7_rx
  import uart_leds7_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50,
  parameter int unsigned BIT_RATE = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_error,
  output logic [6:0] hex0,
  output logic [6:0] hex1
);

  localparam int unsigned CPB   = clks_per_bit(CLK_FREQ, BIT_RATE);
  localparam int unsigned HALF  = CPB / 2;
  localparam int unsigned CNT_W = $clog2(CPB + 1);

  logic [1:0]       rx_sync;
  logic             rx_s;
  logic             rx_prev;
  rx_state_t        state;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic [6:0]       seg_lo_c;
  logic [6:0]       seg_hi_c;

  assign rx_s = rx_sync[1];

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_sync <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[0], uart_rx};
      rx_prev <= rx_s;
    end
  end

  // Receiver state machine with registered data and status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      clk_cnt     <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      data        <= '0;
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
      case (state)
        IDLE: begin
          clk_cnt <= '0;
          if (rx_prev && !rx_s) begin
            state   <= START;
            bit_cnt <= '0;
          end
        end
        START: begin
          // Re-check the line at mid start bit to reject glitches.
          if (clk_cnt == CNT_W'(HALF - 1)) begin
            clk_cnt <= '0;
            state   <= rx_s ? IDLE : DATA;
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (clk_cnt == CNT_W'(CPB - 1)) begin
            clk_cnt <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= STOP;
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (clk_cnt == CNT_W'(CPB - 1)) begin
            clk_cnt <= '0;
            if (rx_s) begin
              data       <= shreg;
              data_valid <= 1'b1;
              state      <= IDLE;
            end else begin
              frame_error <= 1'b1;
              state       <= WAIT_HIGH;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        WAIT_HIGH: begin
          // Hold off until a break ends so it is not taken as a start bit.
          clk_cnt <= '0;
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  hex_to_7seg u_hex_lo (.value(data[3:0]), .seg_c(seg_lo_c));
  hex_to_7seg u_hex_hi (.value(data[7:4]), .seg_c(seg_hi_c));

  // Display registers trail data by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      hex0 <= SEG_LUT[0];
      hex1 <= SEG_LUT[0];
    end else begin
      hex0 <= seg_lo_c;
      hex1 <= seg_hi_c;
    end
  end

endmodule

// File: tb/tb_uart_leds7_rx.sv
// Self-checking bench for uart_leds7_rx: serial frames at 115200 bit/s on a
// 50 MHz clock, checked against a queue of expected bytes and a digit table.
module tb_uart_leds7_rx;

  localparam int CPB = (50 * 1_000_000 + 115200 / 2) / 115200;

  logic       clk = 1'b0;
  logic       reset;
  logic       uart_rx;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_error;
  logic [6:0] hex0;
  logic [6:0] hex1;

  int tests_run    = 0;
  int tests_failed = 0;

  int         dv_cnt   = 0;
  int         fe_cnt   = 0;
  int         both_cnt = 0;
  logic [7:0] rx_q[$];
  logic [7:0] last_good = 8'h00;

  logic [6:0] seg_ref [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  uart_leds7_rx #(.CLK_FREQ(50), .BIT_RATE(115200)) dut (
    .clk(clk), .reset(reset), .uart_rx(uart_rx), .data(data),
    .data_valid(data_valid), .frame_error(frame_error),
    .hex0(hex0), .hex1(hex1)
  );

  always #10 clk = ~clk;

  // Observe pulses away from the active edge.
  always @(negedge clk) begin
    if (data_valid) begin
      dv_cnt++;
      rx_q.push_back(data);
    end
    if (frame_error) fe_cnt++;
    if (data_valid && frame_error) both_cnt++;
  end

  task automatic drive_bit(input logic v);
    uart_rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int stop_bits);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    for (int i = 0; i < stop_bits; i++) drive_bit(stop);
    uart_rx = 1'b1;
  endtask

  task automatic idle_bits(input int n);
    uart_rx = 1'b1;
    repeat (n * CPB) @(negedge clk);
  endtask

  task automatic test_reset();
    uart_rx = 1'b1;
    reset   = 1'b1;
    repeat (15) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    tests_run++; if (data !== 8'h00) begin tests_failed++; $display("FAIL reset_data: got %h want 00", data); end
    tests_run++; if (hex0 !== 7'h40) begin tests_failed++; $display("FAIL reset_hex0: got %h want 40", hex0); end
    tests_run++; if (hex1 !== 7'h40) begin tests_failed++; $display("FAIL reset_hex1: got %h want 40", hex1); end
    tests_run++; if (dv_cnt !== 0) begin tests_failed++; $display("FAIL reset_dv: got %0d pulses want 0", dv_cnt); end
    tests_run++; if (fe_cnt !== 0) begin tests_failed++; $display("FAIL reset_fe: got %0d pulses want 0", fe_cnt); end
  endtask

  task automatic test_single();
    int dv0 = dv_cnt;
    int qb  = rx_q.size();
    logic [7:0] b = 8'hA5;
    logic [3:0] hi = b[7:4];
    logic [3:0] lo = b[3:0];
    send_frame(b, 1'b1, 1);
    repeat (4) @(negedge clk);
    last_good = b;
    tests_run++; if (dv_cnt - dv0 !== 1) begin tests_failed++; $display("FAIL single_dv: got %0d pulses want 1", dv_cnt - dv0); end
    tests_run++; if (rx_q.size() <= qb || rx_q[qb] !== b) begin tests_failed++; $display("FAIL single_byte: got queue size %0d want first %h", rx_q.size() - qb, b); end
    tests_run++; if (data !== b) begin tests_failed++; $display("FAIL single_data: got %h want %h", data, b); end
    tests_run++; if (hex1 !== seg_ref[hi]) begin tests_failed++; $display("FAIL single_hex1: got %h want %h", hex1, seg_ref[hi]); end
    tests_run++; if (hex0 !== seg_ref[lo]) begin tests_failed++; $display("FAIL single_hex0: got %h want %h", hex0, seg_ref[lo]); end
  endtask

  task automatic test_random_stream();
    int dv0 = dv_cnt;
    int fe0 = fe_cnt;
    int qb  = rx_q.size();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int gap;
    for (int i = 0; i < 10; i++) begin
      b   = 8'($urandom);
      gap = (i == 2 || i == 6) ? 0 : int'($urandom_range(0, 30));
      exp_q.push_back(b);
      send_frame(b, 1'b1, 1);
      if (gap > 0) idle_bits(gap);
    end
    repeat (4) @(negedge clk);
    last_good = exp_q[9];
    tests_run++; if (dv_cnt - dv0 !== 10) begin tests_failed++; $display("FAIL stream_dv: got %0d pulses want 10", dv_cnt - dv0); end
    tests_run++; if (fe_cnt - fe0 !== 0) begin tests_failed++; $display("FAIL stream_fe: got %0d pulses want 0", fe_cnt - fe0); end
    for (int i = 0; i < 10; i++) begin
      tests_run++;
      if (rx_q.size() <= qb + i || rx_q[qb + i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL stream_byte%0d: got %h want %h", i, (rx_q.size() > qb + i) ? rx_q[qb + i] : 8'hxx, exp_q[i]);
      end
    end
    tests_run++; if (data !== last_good) begin tests_failed++; $display("FAIL stream_data: got %h want %h", data, last_good); end
  endtask

  task automatic test_glitch();
    int dv0 = dv_cnt;
    int fe0 = fe_cnt;
    int qb;
    uart_rx = 1'b0;
    repeat (100) @(negedge clk);
    idle_bits(2);
    tests_run++; if (dv_cnt - dv0 !== 0) begin tests_failed++; $display("FAIL glitch_dv: got %0d pulses want 0", dv_cnt - dv0); end
    tests_run++; if (fe_cnt - fe0 !== 0) begin tests_failed++; $display("FAIL glitch_fe: got %0d pulses want 0", fe_cnt - fe0); end
    tests_run++; if (dut.state !== uart_leds7_pkg::IDLE) begin tests_failed++; $display("FAIL glitch_state: got %0d want IDLE", dut.state); end
    tests_run++; if (data !== last_good) begin tests_failed++; $display("FAIL glitch_data: got %h want %h", data, last_good); end
    qb = rx_q.size();
    send_frame(8'h3C, 1'b1, 1);
    repeat (4) @(negedge clk);
    last_good = 8'h3C;
    tests_run++; if (rx_q.size() != qb + 1 || data !== 8'h3C) begin tests_failed++; $display("FAIL glitch_next: got %h (%0d pulses) want 3c (1 pulse)", data, rx_q.size() - qb); end
  endtask

  task automatic test_framing();
    int dv0 = dv_cnt;
    int fe0 = fe_cnt;
    int qb;
    logic [7:0] b;
    send_frame(8'h7E, 1'b0, 2);
    idle_bits(2);
    tests_run++; if (fe_cnt - fe0 !== 1) begin tests_failed++; $display("FAIL frame_fe: got %0d pulses want 1", fe_cnt - fe0); end
    tests_run++; if (dv_cnt - dv0 !== 0) begin tests_failed++; $display("FAIL frame_dv: got %0d pulses want 0", dv_cnt - dv0); end
    tests_run++; if (data !== last_good) begin tests_failed++; $display("FAIL frame_data: got %h want %h", data, last_good); end
    qb = rx_q.size();
    b  = 8'($urandom);
    send_frame(b, 1'b1, 1);
    repeat (4) @(negedge clk);
    last_good = b;
    tests_run++; if (rx_q.size() != qb + 1 || data !== b) begin tests_failed++; $display("FAIL frame_next: got %h (%0d pulses) want %h (1 pulse)", data, rx_q.size() - qb, b); end
  endtask

  task automatic test_reset_midframe();
    int dv0 = dv_cnt;
    int fe0 = fe_cnt;
    int qb;
    logic [7:0] b = 8'h5A;
    logic [7:0] nb = 8'h81;
    logic [3:0] hi = nb[7:4];
    logic [3:0] lo = nb[3:0];
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    uart_rx = b[4];
    repeat (CPB / 2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle_bits(2);
    last_good = 8'h00;
    tests_run++; if (dv_cnt - dv0 !== 0 || fe_cnt - fe0 !== 0) begin tests_failed++; $display("FAIL rstmid_pulses: got dv %0d fe %0d want 0 0", dv_cnt - dv0, fe_cnt - fe0); end
    tests_run++; if (data !== 8'h00) begin tests_failed++; $display("FAIL rstmid_data: got %h want 00", data); end
    tests_run++; if (hex0 !== 7'h40 || hex1 !== 7'h40) begin tests_failed++; $display("FAIL rstmid_hex: got %h %h want 40 40", hex1, hex0); end
    qb = rx_q.size();
    send_frame(nb, 1'b1, 1);
    repeat (4) @(negedge clk);
    last_good = nb;
    tests_run++; if (rx_q.size() != qb + 1 || data !== nb) begin tests_failed++; $display("FAIL rstmid_next: got %h (%0d pulses) want 81 (1 pulse)", data, rx_q.size() - qb); end
    tests_run++; if (hex1 !== seg_ref[hi] || hex0 !== seg_ref[lo]) begin tests_failed++; $display("FAIL rstmid_nexthex: got %h %h want %h %h", hex1, hex0, seg_ref[hi], seg_ref[lo]); end
    tests_run++; if (both_cnt !== 0) begin tests_failed++; $display("FAIL overlap: got %0d cycles with both pulses want 0", both_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_random_stream();
    test_glitch();
    test_framing();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
